nic_tx: RTL

Network-interface transmitter that injects packets from a local core into a router input channel.
- Segments each core packet into head/body/tail flits.
- Picks a virtual channel per packet and holds it until the tail (wormhole).
- Drives the router-side idata/ivalid/ivch triple, throttled per VC by the router's per-VC ready vector.
- Sits between the core and the router's local input port; it is the sending end of that port's flit interface.

---
 rtl/nic_tx.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/nic_tx.sv
// nic_tx: network-interface transmitter. Takes packet descriptors and payload words
// from the local core, then drives head/body/tail flits into the router's local input
// port. Each packet picks a VC round-robin among the router's ready VCs and keeps it
// until the tail.
// Optional feature: define NIC_TX_STATS_EN to add the pkt_cnt output. It counts
// completed packets and wraps at 16 bits.
// The flit layout macros below fall back to a default layout when no global
// definitions exist: a 32-bit flit with TYPE[31:29], VCH[28], DST[27:24] and 2 VCs.

`ifndef DATAW
`define DATAW 31
`endif
`ifndef VCH
`define VCH 1
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 31
`endif
`ifndef TYPE_LSB
`define TYPE_LSB 29
`endif
`ifndef VCH_MSB
`define VCH_MSB 28
`endif
`ifndef VCH_LSB
`define VCH_LSB 28
`endif
`ifndef DST_MSB
`define DST_MSB 27
`endif
`ifndef DST_LSB
`define DST_LSB 24
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 3'b001
`endif
`ifndef TYPE_BODY
`define TYPE_BODY 3'b010
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 3'b011
`endif
`ifndef TYPE_HEADTAIL
`define TYPE_HEADTAIL 3'b100
`endif

module nic_tx #(
   parameter int unsigned ROUTERID = 0,
   parameter int unsigned LENW     = 3
) (
   input  logic                         clk,
   input  logic                         rst_,
   input  logic                         pkt_valid,
   input  logic [`DST_MSB-`DST_LSB:0]   pkt_dst,
   input  logic [LENW:0]                pkt_len,
   output logic                         pkt_ack,
   input  logic [`DATAW:0]              pay_data,
   input  logic                         pay_valid,
   output logic                         pay_ready,
   output logic [`DATAW:0]              odata,
   output logic                         ovalid,
   output logic [`VCHW:0]               ovch,
   input  logic [`VCH:0]                irdy,
`ifdef NIC_TX_STATS_EN
   output logic [15:0]                  pkt_cnt,
`endif
   output logic                         busy
);

   localparam int NumVc = `VCH + 1;
   localparam logic [LENW:0] LenOne = (LENW + 1)'(1);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e                       state_q, state_d;
   logic [`VCHW:0]               vc_q, vc_d;
   logic [`VCHW:0]               rr_q, rr_d;
   logic [LENW:0]                len_q, len_d;
   logic [LENW:0]                cnt_q, cnt_d;
   logic [`DST_MSB-`DST_LSB:0]   dst_q, dst_d;
   logic                         ack_d;
   logic                         pick_ok;
   logic [`VCHW:0]               pick_vc;
   logic                         xfer;
   logic                         first;
   logic                         last;
   logic [`TYPE_MSB-`TYPE_LSB:0] ftype;
   logic [`DATAW:0]              flit;

   // Round-robin VC pick: first ready VC after the last-used one. Scanning from the
   // farthest candidate down lets the nearest ready candidate win.
   always_comb begin
      int             cand;
      logic [`VCHW:0] c;
      pick_ok = 1'b0;
      pick_vc = rr_q;
      for (int k = NumVc; k >= 1; k--) begin
         cand = (int'(rr_q) + k) % NumVc;
         c    = cand[`VCHW:0];
         if (irdy[c]) begin
            pick_ok = 1'b1;
            pick_vc = c;
         end
      end
   end

   // Handshake decode; pay_ready depends only on the router side and the held VC.
   always_comb begin
      busy      = (state_q == StSend);
      pay_ready = busy && irdy[vc_q];
      xfer      = pay_ready && pay_valid;
      first     = (cnt_q == '0);
      last      = (cnt_q == len_q - LenOne);
   end

   // Next-state: descriptor acceptance in idle, flit counting in send.
   always_comb begin
      state_d = state_q;
      vc_d    = vc_q;
      rr_d    = rr_q;
      len_d   = len_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pkt_valid && pick_ok) begin
               vc_d    = pick_vc;
               rr_d    = pick_vc;
               len_d   = (pkt_len == '0) ? LenOne : pkt_len;
               dst_d   = pkt_dst;
               cnt_d   = '0;
               ack_d   = 1'b1;
               state_d = StSend;
            end
         end
         StSend: begin
            if (xfer) begin
               cnt_d = cnt_q + LenOne;
               if (last) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Flit assembly: the TYPE field is always overwritten, and routing fields only on the head.
   always_comb begin
      if (len_q == LenOne) ftype = `TYPE_HEADTAIL;
      else if (first)      ftype = `TYPE_HEAD;
      else if (last)       ftype = `TYPE_TAIL;
      else                 ftype = `TYPE_BODY;
      flit = pay_data;
      flit[`TYPE_MSB:`TYPE_LSB] = ftype;
      if (first) begin
         flit[`DST_MSB:`DST_LSB] = dst_q;
         flit[`VCH_MSB:`VCH_LSB] = vc_q;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         state_q <= StIdle;
         vc_q    <= '0;
         rr_q    <= (`VCHW + 1)'(1);
         len_q   <= LenOne;
         cnt_q   <= '0;
         dst_q   <= '0;
         pkt_ack <= 1'b0;
      end else begin
         state_q <= state_d;
         vc_q    <= vc_d;
         rr_q    <= rr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         dst_q   <= dst_d;
         pkt_ack <= ack_d;
      end
   end

   // Registered router-side outputs; odata reads as zero whenever no flit is presented.
   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         odata  <= '0;
         ovalid <= 1'b0;
         ovch   <= '0;
      end else begin
         ovalid <= xfer;
         odata  <= xfer ? flit : '0;
         if (xfer) ovch <= vc_q;
      end
   end

`ifdef NIC_TX_STATS_EN
   // Completed-packet counter; the natural 16-bit wrap is intended.
   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) pkt_cnt <= '0;
      else if (xfer && last) pkt_cnt <= pkt_cnt + 16'd1;
   end
`endif

endmodule
